rs_nand: RTL and testbench

- Synchronous, cycle-accurate model of a cross-coupled NAND RS latch with active-low inputs Sn and Rn.
- Provides Q/Qn, plus status flags for the NAND-forbidden input (both inputs low) and the race condition on leaving it.
- Sits in lock/control logic as a registered, glitch-free replacement for an asynchronous latch.
- Inputs may be asynchronous; they pass through a configurable synchronizer.

---
 rtl/rs_nand_if.sv | 45 ++++
 rtl/rs_nand.sv | 186 ++++++++++++++++++
 tb/tb_rs_nand.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_nand_if.sv
// Pin bundle for the registered NAND RS latch; counter signals exist only when
// RS_NAND_EVENT_CNT_EN is defined.
interface rs_nand_if #(
   parameter int CNT_W = 8
);

   logic Sn;
   logic Rn;
   logic Q;
   logic Qn;
   logic stored;
   logic forbidden;
   logic race;

`ifdef RS_NAND_EVENT_CNT_EN
   logic [CNT_W-1:0] set_cnt;
   logic [CNT_W-1:0] rst_cnt;
   logic [CNT_W-1:0] forb_cnt;

   modport master (
      output Sn, Rn,
      input  Q, Qn, stored, forbidden, race, set_cnt, rst_cnt, forb_cnt
   );

   modport slave (
      input  Sn, Rn,
      output Q, Qn, stored, forbidden, race, set_cnt, rst_cnt, forb_cnt
   );
`else
   modport master (
      output Sn, Rn,
      input  Q, Qn, stored, forbidden, race
   );

   modport slave (
      input  Sn, Rn,
      output Q, Qn, stored, forbidden, race
   );
`endif

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("rs_nand_if: CNT_W must be at least 1");
   end

endinterface

// File: rtl/rs_nand.sv
// Registered, glitch-free model of a cross-coupled NAND RS latch with input
// synchronizer; define RS_NAND_EVENT_CNT_EN to add saturating event counters.
module rs_nand #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input logic     clk,
   input logic     rst,
   rs_nand_if.slave bus
);

   localparam logic [1:0] SR_FORB = 2'b00;
   localparam logic [1:0] SR_SET  = 2'b01;
   localparam logic [1:0] SR_CLR  = 2'b10;
   localparam logic [1:0] SR_HOLD = 2'b11;

   // The FORB states remember which value was held before entering 00.
   typedef enum logic [1:0] {
      ST_LOW       = 2'b00,
      ST_HIGH      = 2'b01,
      ST_FORB_LOW  = 2'b10,
      ST_FORB_HIGH = 2'b11
   } state_t;

   if (SYNC_STAGES < 0 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("rs_nand: SYNC_STAGES must be in 0..4");
   end

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("rs_nand: CNT_W must be at least 1");
   end

   // ---- stage p0: synchronized inputs ----
   logic       s_p0;
   logic       r_p0;
   logic [1:0] sr_p0;
   logic [1:0] sr_prev;

   if (SYNC_STAGES == 0) begin : g_nosync
      assign s_p0 = bus.Sn;
      assign r_p0 = bus.Rn;
   end else begin : g_sync
      logic [SYNC_STAGES-1:0] sn_sync;
      logic [SYNC_STAGES-1:0] rn_sync;

      // Loading ones on reset makes release look like a plain hold.
      always_ff @(posedge clk) begin
         if (rst) begin
            sn_sync <= '1;
            rn_sync <= '1;
         end else begin
            sn_sync[0] <= bus.Sn;
            rn_sync[0] <= bus.Rn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sn_sync[i] <= sn_sync[i-1];
               rn_sync[i] <= rn_sync[i-1];
            end
         end
      end

      assign s_p0 = sn_sync[SYNC_STAGES-1];
      assign r_p0 = rn_sync[SYNC_STAGES-1];
   end

   assign sr_p0 = {s_p0, r_p0};

   // ---- stage p1: latch state and registered outputs ----
   state_t state_p1;
   state_t state_nxt;
   logic   q_p1, qn_p1, stored_p1, forb_p1, race_p1;
   logic   q_nxt, qn_nxt, stored_nxt, forb_nxt, race_nxt;
   logic   held_high;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p1  <= ST_LOW;
         q_p1      <= 1'b0;
         qn_p1     <= 1'b1;
         stored_p1 <= 1'b0;
         forb_p1   <= 1'b0;
         race_p1   <= 1'b0;
         sr_prev   <= SR_HOLD;
      end else begin
         state_p1  <= state_nxt;
         q_p1      <= q_nxt;
         qn_p1     <= qn_nxt;
         stored_p1 <= stored_nxt;
         forb_p1   <= forb_nxt;
         race_p1   <= race_nxt;
         sr_prev   <= sr_p0;
      end
   end

   always_comb begin
      state_nxt  = state_p1;
      q_nxt      = 1'b0;
      qn_nxt     = 1'b1;
      stored_nxt = 1'b0;
      forb_nxt   = 1'b0;
      race_nxt   = 1'b0;
      held_high  = (state_p1 == ST_HIGH) || (state_p1 == ST_FORB_HIGH);

      case (sr_p0)
         SR_SET:  state_nxt = ST_HIGH;
         SR_CLR:  state_nxt = ST_LOW;
         SR_HOLD: state_nxt = held_high ? ST_HIGH : ST_LOW;
         SR_FORB: state_nxt = held_high ? ST_FORB_HIGH : ST_FORB_LOW;
         default: state_nxt = state_p1;
      endcase

      case (state_nxt)
         ST_HIGH: begin
            q_nxt      = 1'b1;
            qn_nxt     = 1'b0;
            stored_nxt = 1'b1;
         end
         ST_FORB_LOW: begin
            q_nxt    = 1'b1;
            qn_nxt   = 1'b1;
            forb_nxt = 1'b1;
         end
         ST_FORB_HIGH: begin
            q_nxt      = 1'b1;
            qn_nxt     = 1'b1;
            stored_nxt = 1'b1;
            forb_nxt   = 1'b1;
         end
         default: begin
            q_nxt  = 1'b0;
            qn_nxt = 1'b1;
         end
      endcase

      // Only a direct 00 -> 11 step races; 01/10 exits resolve normally.
      race_nxt = (sr_prev == SR_FORB) && (sr_p0 == SR_HOLD);
   end

   assign bus.Q         = q_p1;
   assign bus.Qn        = qn_p1;
   assign bus.stored    = stored_p1;
   assign bus.forbidden = forb_p1;
   assign bus.race      = race_p1;

`ifdef RS_NAND_EVENT_CNT_EN
   // ---- stage p1: event counters, edges into a state only ----
   logic [CNT_W-1:0] set_cnt_p1;
   logic [CNT_W-1:0] rst_cnt_p1;
   logic [CNT_W-1:0] forb_cnt_p1;
   logic             set_edge, clr_edge, forb_edge;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign set_edge  = (sr_p0 == SR_SET)  && (sr_prev != SR_SET);
   assign clr_edge  = (sr_p0 == SR_CLR)  && (sr_prev != SR_CLR);
   assign forb_edge = (sr_p0 == SR_FORB) && (sr_prev != SR_FORB);

   always_ff @(posedge clk) begin
      if (rst) begin
         set_cnt_p1  <= '0;
         rst_cnt_p1  <= '0;
         forb_cnt_p1 <= '0;
      end else begin
         if (set_edge)  set_cnt_p1  <= sat_inc(set_cnt_p1);
         if (clr_edge)  rst_cnt_p1  <= sat_inc(rst_cnt_p1);
         if (forb_edge) forb_cnt_p1 <= sat_inc(forb_cnt_p1);
      end
   end

   assign bus.set_cnt  = set_cnt_p1;
   assign bus.rst_cnt  = rst_cnt_p1;
   assign bus.forb_cnt = forb_cnt_p1;
`endif

   // Complementary outputs must hold outside forbidden; race never overlaps it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (forb_p1 || (q_p1 != qn_p1))
            else $error("rs_nand: Q and Qn not complementary outside forbidden");
         assert (!(race_p1 && forb_p1))
            else $error("rs_nand: race asserted while forbidden");
      end
   end

endmodule

// File: tb/tb_rs_nand.sv
// Scoreboard bench for rs_nand: a truth-table model pushes expected outputs as
// pins are driven; they are popped once the synchronizer latency has elapsed.
module tb_rs_nand;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [4:0] exp_q[$];
   logic       st_m;
   logic [1:0] prev_m;

   always #5 clk = ~clk;

   rs_nand_if #(.CNT_W(2)) bus ();

   rs_nand #(.SYNC_STAGES(2), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      rst    = 1'b1;
      bus.Sn = 1'b1;
      bus.Rn = 1'b1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] obs();
      return {bus.Q, bus.Qn, bus.stored, bus.forbidden, bus.race};
   endfunction

   // Drive one input pair, advance the model, then sample after the edge.
   task automatic cycle(input logic sn, input logic rn,
                        output logic have, output logic [4:0] e);
      logic [1:0] in;
      logic [4:0] v;
      @(negedge clk);
      bus.Sn = sn;
      bus.Rn = rn;
      in = {sn, rn};
      v  = '0;
      case (in)
         2'b01: begin st_m = 1'b1; v[4:1] = 4'b1010; end
         2'b10: begin st_m = 1'b0; v[4:1] = 4'b0100; end
         2'b11: v[4:1] = {st_m, ~st_m, st_m, 1'b0};
         default: v[4:1] = {1'b1, 1'b1, st_m, 1'b1};
      endcase
      v[0]   = (prev_m == 2'b00) && (in == 2'b11);
      prev_m = in;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      have = 1'b0;
      e    = '0;
      if (exp_q.size() >= 3) begin
         e    = exp_q.pop_front();
         have = 1'b1;
      end
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      rst    = 1'b1;
      bus.Sn = 1'b1;
      bus.Rn = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      st_m   = 1'b0;
      prev_m = 2'b11;
   endtask

   task automatic test_reset();
      logic have;
      logic [4:0] e;
      @(negedge clk);
      rst    = 1'b1;
      bus.Sn = 1'b1;
      bus.Rn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (obs() !== 5'b01000) begin
            bad++;
            $display("FAIL reset_hold cycle=%0d got=%b exp=01000", i, obs());
         end
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      st_m   = 1'b0;
      prev_m = 2'b11;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b1, have, e);
         total++;
         if (obs() !== 5'b01000) begin
            bad++;
            $display("FAIL reset_release cycle=%0d got=%b exp=01000", i, obs());
         end
         if (have) begin
            total++;
            if (obs() !== e) begin
               bad++;
               $display("FAIL sb_reset got=%b exp=%b", obs(), e);
            end
         end
      end
   endtask

   task automatic test_set();
      logic have;
      logic [4:0] e;
      for (int i = 0; i < 50; i++) begin
         cycle(1'b0, 1'b1, have, e);
         if (i == 1) begin
            total++;
            if (bus.Q !== 1'b0) begin
               bad++;
               $display("FAIL set_latency got Q=%b exp 0", bus.Q);
            end
         end
         if (i >= 2) begin
            total++;
            if ({bus.Q, bus.Qn, bus.stored} !== 3'b101) begin
               bad++;
               $display("FAIL set_value cycle=%0d got=%b exp=101", i, {bus.Q, bus.Qn, bus.stored});
            end
         end
         if (have) begin
            total++;
            if (obs() !== e) begin
               bad++;
               $display("FAIL sb_set got=%b exp=%b", obs(), e);
            end
         end
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1, have, e);
         total++;
         if ({bus.Q, bus.Qn, bus.forbidden, bus.race} !== 4'b1000) begin
            bad++;
            $display("FAIL set_hold got=%b exp=1000", {bus.Q, bus.Qn, bus.forbidden, bus.race});
         end
      end
   endtask

   task automatic test_clear();
      logic have;
      logic [4:0] e;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 1'b0, have, e);
         if (i >= 2) begin
            total++;
            if ({bus.Q, bus.Qn, bus.stored} !== 3'b010) begin
               bad++;
               $display("FAIL clr_value cycle=%0d got=%b exp=010", i, {bus.Q, bus.Qn, bus.stored});
            end
         end
         if (have) begin
            total++;
            if (obs() !== e) begin
               bad++;
               $display("FAIL sb_clr got=%b exp=%b", obs(), e);
            end
         end
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1, have, e);
         total++;
         if (obs() !== 5'b01000) begin
            bad++;
            $display("FAIL clr_hold got=%b exp=01000", obs());
         end
      end
   endtask

   task automatic test_forbidden_race();
      logic have;
      logic [4:0] e;
      int pulses;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, have, e);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, have, e);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, have, e);
         if (i >= 2) begin
            total++;
            if (obs() !== 5'b11110) begin
               bad++;
               $display("FAIL forb_value cycle=%0d got=%b exp=11110", i, obs());
            end
         end
      end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, have, e);
         if (bus.race === 1'b1) pulses++;
         if (i == 2) begin
            total++;
            if (obs() !== 5'b10101) begin
               bad++;
               $display("FAIL race_exit got=%b exp=10101", obs());
            end
         end
         if (have) begin
            total++;
            if (obs() !== e) begin
               bad++;
               $display("FAIL sb_race got=%b exp=%b", obs(), e);
            end
         end
      end
      total++;
      if (pulses != 1) begin
         bad++;
         $display("FAIL race_pulses got=%0d exp=1", pulses);
      end
   endtask

   task automatic test_exit_no_race();
      logic have;
      logic [4:0] e;
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, have, e);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, have, e);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, have, e);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b1, have, e);
         total++;
         if (bus.race !== 1'b0) begin
            bad++;
            $display("FAIL exit_set_race cycle=%0d got=%b exp=0", i, bus.race);
         end
         if (i >= 2) begin
            total++;
            if ({bus.Q, bus.Qn, bus.forbidden} !== 3'b100) begin
               bad++;
               $display("FAIL exit_set got=%b exp=100", {bus.Q, bus.Qn, bus.forbidden});
            end
         end
      end
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, have, e);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0, have, e);
         total++;
         if (bus.race !== 1'b0) begin
            bad++;
            $display("FAIL exit_clr_race cycle=%0d got=%b exp=0", i, bus.race);
         end
         if (i >= 2) begin
            total++;
            if ({bus.Q, bus.Qn, bus.forbidden} !== 3'b010) begin
               bad++;
               $display("FAIL exit_clr got=%b exp=010", {bus.Q, bus.Qn, bus.forbidden});
            end
         end
      end
   endtask

   task automatic test_reset_in_forbidden();
      logic have;
      logic [4:0] e;
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, have, e);
      total++;
      if (bus.forbidden !== 1'b1) begin
         bad++;
         $display("FAIL rif_pre got forbidden=%b exp 1", bus.forbidden);
      end
      apply_reset(1);
      total++;
      if (obs() !== 5'b01000) begin
         bad++;
         $display("FAIL rif_reset got=%b exp=01000", obs());
      end
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b1, have, e);
         total++;
         if (obs() !== 5'b01000) begin
            bad++;
            $display("FAIL rif_after cycle=%0d got=%b exp=01000", i, obs());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic have;
      logic [4:0] e;
      logic [1:0] pins;
      for (int i = 0; i < 300; i++) begin
         pins = 2'($urandom_range(0, 3));
         cycle(pins[1], pins[0], have, e);
         if (have) begin
            total++;
            if (obs() !== e) begin
               bad++;
               $display("FAIL sb_random cycle=%0d got=%b exp=%b", i, obs(), e);
            end
         end
      end
   endtask

`ifdef RS_NAND_EVENT_CNT_EN
   task automatic test_counters();
      logic have;
      logic [4:0] e;
      apply_reset(2);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b1, have, e);
         cycle(1'b1, 1'b1, have, e);
      end
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, have, e);
      total++;
      if ({bus.set_cnt, bus.rst_cnt, bus.forb_cnt} !== 6'b110000) begin
         bad++;
         $display("FAIL cnt_sat got set=%0d rst=%0d forb=%0d exp 3/0/0",
                  bus.set_cnt, bus.rst_cnt, bus.forb_cnt);
      end
      cycle(1'b1, 1'b0, have, e);
      cycle(1'b1, 1'b0, have, e);
      cycle(1'b0, 1'b0, have, e);
      cycle(1'b0, 1'b0, have, e);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, have, e);
      total++;
      if ({bus.set_cnt, bus.rst_cnt, bus.forb_cnt} !== 6'b110101) begin
         bad++;
         $display("FAIL cnt_edges got set=%0d rst=%0d forb=%0d exp 3/1/1",
                  bus.set_cnt, bus.rst_cnt, bus.forb_cnt);
      end
      apply_reset(1);
      total++;
      if ({bus.set_cnt, bus.rst_cnt, bus.forb_cnt} !== 6'b000000) begin
         bad++;
         $display("FAIL cnt_clear got set=%0d rst=%0d forb=%0d exp 0/0/0",
                  bus.set_cnt, bus.rst_cnt, bus.forb_cnt);
      end
   endtask
`endif

   initial begin
      st_m   = 1'b0;
      prev_m = 2'b11;
      test_reset();
      test_set();
      test_clear();
      test_forbidden_race();
      test_exit_no_race();
      test_reset_in_forbidden();
      test_back_to_back();
`ifdef RS_NAND_EVENT_CNT_EN
      test_counters();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
